// File: rtl/qcmd_capture.sv
// rtl/qcmd_capture.sv - timestamped capture buffer for the sequencer command stream
//
// Logs every strobed command (cstrobe/command/cmda/extra) with its time
// relative to the last trig into a 4-word-per-entry buffer the host can
// read back and replay verbatim.
//
// Parameters:
//   aw  host address width; entry = raddr[aw-1:2], word = raddr[1:0]
//   tw  timestamp width (at most 24 so time and cmda share word 0)
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   trig      start of run: clear buffer and timestamp, arm capture
//   stop      end capture, freeze buffer for readout
//   cstrobe   command-valid strobe
//   command   64-bit command payload
//   cmda      8-bit command address / element select
//   extra     32-bit auxiliary word
//   raddr     host read address
//   rdata     registered host read data (0 for entries not yet written)
//   count     number of valid entries in the current run
//   armed     capture state
//   full      buffer full state
//   overflow  sticky: strobe arrived while full

module qcmd_capture #(
    parameter int aw = 15,
    parameter int tw = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trig,
    input  logic            stop,
    input  logic            cstrobe,
    input  logic [63:0]     command,
    input  logic [7:0]      cmda,
    input  logic [31:0]     extra,
    input  logic [aw-1:0]   raddr,
    output logic [31:0]     rdata,
    output logic [aw-2:0]   count,
    output logic            armed,
    output logic            full,
    output logic            overflow
);

    localparam int depth = 1 << (aw - 2);
    // count value just before the final free slot is consumed
    localparam logic [aw-2:0] last_idx = (aw - 1)'(depth - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_FULL
    } state_t;

    state_t          state;
    logic [tw-1:0]   ts;

    // one 128-bit entry: {word0, command[63:32], command[31:0], extra}
    logic [127:0]    mem [depth];

    logic            wr_en;
    logic [aw-3:0]   wr_idx;
    logic [tw-1:0]   rec_time;
    logic [31:0]     word0;

    logic [aw-3:0]   rd_idx;
    logic [1:0]      rd_word;
    logic [127:0]    rd_entry;
    logic [31:0]     rd_sel;
    logic            rd_valid;

    // Write only in CAPTURE when neither trig nor stop takes priority.
    always_comb begin
        wr_en    = (state == S_CAPTURE) && cstrobe && !trig && !stop;
        wr_idx   = count[aw-3:0];
        // The sequencer registers its strobe once, so the command was due
        // one cycle before we see it.
        rec_time = ts - tw'(1);
        word0    = {rec_time, {(32 - tw){1'b0}}} | {24'd0, cmda};
    end

    // Buffer contents are never reset; count gates visibility instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= {word0, command, extra};
        end
    end

    always_comb begin
        rd_idx   = raddr[aw-1:2];
        rd_word  = raddr[1:0];
        rd_entry = mem[rd_idx];
        rd_valid = ({1'b0, rd_idx} < count);
        rd_sel   = 32'd0;
        case (rd_word)
            2'd0: rd_sel = rd_entry[127:96];
            2'd1: rd_sel = rd_entry[95:64];
            2'd2: rd_sel = rd_entry[63:32];
            2'd3: rd_sel = rd_entry[31:0];
            default: rd_sel = 32'd0;
        endcase
    end

    // Validity uses the pre-update count, so an entry written this cycle
    // reads as 0 until the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 32'd0;
        end else if (rd_valid) begin
            rdata <= rd_sel;
        end else begin
            rdata <= 32'd0;
        end
    end

    // Control FSM: priority trig > stop > cstrobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ts       <= '0;
            count    <= '0;
            overflow <= 1'b0;
            armed    <= 1'b0;
            full     <= 1'b0;
        end else begin
            ts <= trig ? '0 : ts + tw'(1);

            if (trig) begin
                state    <= S_CAPTURE;
                count    <= '0;
                overflow <= 1'b0;
                armed    <= 1'b1;
                full     <= 1'b0;
            end else if (stop && state != S_IDLE) begin
                state <= S_IDLE;
                armed <= 1'b0;
                full  <= 1'b0;
            end else if (cstrobe && !stop) begin
                case (state)
                    S_CAPTURE: begin
                        count <= count + (aw - 1)'(1);
                        if (count == last_idx) begin
                            state <= S_FULL;
                            armed <= 1'b0;
                            full  <= 1'b1;
                        end
                    end
                    S_FULL: begin
                        overflow <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qcmd_capture.sv
// tb/tb_qcmd_capture.sv - self-checking bench for qcmd_capture
module tb_qcmd_capture;

    localparam int AW    = 4;
    localparam int TW    = 10;
    localparam int DEPTH = 1 << (AW - 2);
    localparam int TMOD  = 1 << TW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          trig = 1'b0;
    logic          stop = 1'b0;
    logic          cstrobe = 1'b0;
    logic [63:0]   command = '0;
    logic [7:0]    cmda = '0;
    logic [31:0]   extra = '0;
    logic [AW-1:0] raddr = '0;
    logic [31:0]   rdata;
    logic [AW-2:0] count;
    logic          armed;
    logic          full;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
    } ent_t;

    ent_t        mq[$];
    bit          m_run = 1'b0;
    bit          m_ovf = 1'b0;
    int unsigned m_ts  = 0;

    qcmd_capture #(.aw(AW), .tw(TW)) dut (
        .clk      (clk),
        .rst      (rst),
        .trig     (trig),
        .stop     (stop),
        .cstrobe  (cstrobe),
        .command  (command),
        .cmda     (cmda),
        .extra    (extra),
        .raddr    (raddr),
        .rdata    (rdata),
        .count    (count),
        .armed    (armed),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ent_word(input ent_t e, input logic [1:0] w);
        case (w)
            2'd0: return e.w0;
            2'd1: return e.w1;
            2'd2: return e.w2;
            default: return e.w3;
        endcase
    endfunction

    // One clock: reference model steps at the edge, outputs checked on the falling edge.
    task automatic cyc();
        logic [31:0] exp_rd;
        int          idx;
        int unsigned t;
        ent_t        e;
        @(posedge clk);
        idx    = int'(raddr[AW-1:2]);
        exp_rd = 32'd0;
        if (idx < mq.size()) exp_rd = ent_word(mq[idx], raddr[1:0]);
        t = (m_ts + TMOD - 1) % TMOD;
        if (trig) begin
            mq.delete();
            m_run = 1'b1;
            m_ovf = 1'b0;
        end else if (stop) begin
            m_run = 1'b0;
        end else if (cstrobe && m_run) begin
            if (mq.size() < DEPTH) begin
                e.w0 = (t << (32 - TW)) | 32'(cmda);
                e.w1 = command[63:32];
                e.w2 = command[31:0];
                e.w3 = extra;
                mq.push_back(e);
            end else begin
                m_ovf = 1'b1;
            end
        end
        m_ts = trig ? 0 : (m_ts + 1) % TMOD;
        @(negedge clk);
        chk("cyc_count", 32'(count), 32'(mq.size()));
        chk("cyc_armed", 32'(armed), 32'(m_run && mq.size() < DEPTH));
        chk("cyc_full", 32'(full), 32'(m_run && mq.size() == DEPTH));
        chk("cyc_overflow", 32'(overflow), 32'(m_ovf));
        chk("cyc_rdata", rdata, exp_rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            raddr = AW'($urandom);
            cyc();
        end
    endtask

    task automatic sb(input logic [7:0] a);
        command = {$urandom, $urandom};
        extra   = $urandom;
        cmda    = a;
        cstrobe = 1'b1;
        cyc();
        cstrobe = 1'b0;
    endtask

    task automatic do_trig();
        trig = 1'b1;
        cyc();
        trig = 1'b0;
    endtask

    task automatic rd(input int a);
        raddr = AW'(a);
        cyc();
    endtask

    initial begin
        // reset values
        #12;
        chk("rst_count", 32'(count), 0);
        chk("rst_armed", 32'(armed), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_rdata", rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(3);

        // three commands recorded at 5, 9, 20 (strobe in cycle k after trig -> k-2)
        do_trig();
        idle(6);  sb(8'd1);
        idle(3);  sb(8'd2);
        idle(10); sb(8'd3);
        for (int a = 0; a < 16; a++) rd(a);
        rd(0);  chk("t1_e0w0", rdata, (32'd5 << (32 - TW)) | 32'd1);
        rd(4);  chk("t1_e1w0", rdata, (32'd9 << (32 - TW)) | 32'd2);
        rd(8);  chk("t1_e2w0", rdata, (32'd20 << (32 - TW)) | 32'd3);
        rd(12); chk("t1_e3w0", rdata, 0);
        chk("t1_count", 32'(count), 3);

        // fill, then overflow
        do_trig();
        for (int i = 0; i < 6; i++) begin
            sb(8'(i + 16));
            if (i == 3) begin
                chk("t2_full4", 32'(full), 1);
                chk("t2_ovf4", 32'(overflow), 0);
            end
            if (i == 4) chk("t2_ovf5", 32'(overflow), 1);
        end
        chk("t2_count", 32'(count), 4);
        for (int a = 0; a < 16; a++) rd(a);

        // trig with coincident strobe while full and overflowed
        trig = 1'b1; cstrobe = 1'b1;
        cyc();
        trig = 1'b0; cstrobe = 1'b0;
        chk("t3_count", 32'(count), 0);
        chk("t3_ovf", 32'(overflow), 0);
        chk("t3_armed", 32'(armed), 1);
        idle(10);
        sb(8'h55);
        rd(0);
        chk("t3_time", rdata >> (32 - TW), 9);

        // stop mid-run
        do_trig();
        sb(8'd7); sb(8'd8);
        stop = 1'b1; cyc(); stop = 1'b0;
        sb(8'd9); sb(8'd10); sb(8'd11);
        chk("t4_count", 32'(count), 2);
        chk("t4_armed", 32'(armed), 0);
        chk("t4_ovf", 32'(overflow), 0);
        for (int a = 0; a < 12; a++) rd(a);

        // asynchronous reset mid-cycle during capture
        do_trig();
        sb(8'd1); sb(8'd2); sb(8'd3);
        #2 rst = 1'b1;
        mq.delete(); m_run = 1'b0; m_ovf = 1'b0; m_ts = 0;
        #1;
        chk("t5_count", 32'(count), 0);
        chk("t5_armed", 32'(armed), 0);
        chk("t5_full", 32'(full), 0);
        chk("t5_ovf", 32'(overflow), 0);
        chk("t5_rdata", rdata, 0);
        #1 rst = 1'b0;
        rd(0); chk("t5_rd0", rdata, 0);
        do_trig();
        idle(1);
        sb(8'h21);
        rd(0); chk("t5_time0", rdata, 32'h21);

        // timestamp wrap: strobe in cycle 2^TW+5 -> time 3
        do_trig();
        idle(TMOD + 4);
        sb(8'h33);
        rd(0); chk("t6_wrap", rdata, (32'd3 << (32 - TW)) | 32'h33);

        // same-cycle write/read of entry 1
        do_trig();
        sb(8'h66);
        raddr = AW'(4);
        sb(8'h77);
        chk("t7_same", rdata, 0);
        rd(4);
        chk("t7_next", rdata, 32'h77);

        // randomized run
        for (int i = 0; i < 400; i++) begin
            trig    = ($urandom % 40) == 0;
            stop    = ($urandom % 30) == 0;
            cstrobe = ($urandom % 2) == 0;
            command = {$urandom, $urandom};
            extra   = $urandom;
            cmda    = 8'($urandom);
            raddr   = AW'($urandom);
            cyc();
        end
        trig = 1'b0; stop = 1'b0; cstrobe = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
